// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared widths, FSM state encoding and LRU types for the
//               4-way set-associative data cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  localparam int ADR_WIDTH     = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int WORD_OFFSET   = 2;
  localparam int BYTE_OFFSET   = 2;
  localparam int DATAMEM_WIDTH = 128;
  localparam int INDEX_WIDTH   = 8;
  localparam int TAG_WIDTH     = ADR_WIDTH - INDEX_WIDTH - WORD_OFFSET - BYTE_OFFSET;
  localparam int NUM_SETS      = 1 << INDEX_WIDTH;
  localparam int NUM_WAYS      = 4;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_REFILL = 3'd3,
    ST_RESP   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef logic [1:0] way_t;
  typedef logic [1:0] age_t;
  // Age per way: 0 = most recently used, NUM_WAYS-1 = least recently used.
  typedef age_t [NUM_WAYS-1:0] lru_t;

  localparam lru_t LRU_RESET = {2'd3, 2'd2, 2'd1, 2'd0};

  // Big-endian byte lane: byte 0 lives in bits [31:24].
  function automatic logic [DATA_WIDTH-1:0] load_byte(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            sel,
    input logic                  sign_ext
  );
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return sign_ext ? {{(DATA_WIDTH-8){b[7]}}, b} : {{(DATA_WIDTH-8){1'b0}}, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_lru.sv
`default_nettype none
// ============================================================================
// Module      : cache_lru
// Description : True-LRU age update and victim selection for one 4-way set.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_lru
  import cache_pkg::*;
(
  input  lru_t                lru_i,
  input  logic [NUM_WAYS-1:0] valid_i,
  input  way_t                touch_way_i,
  output lru_t                lru_o,
  output way_t                victim_o
);

  logic found;

  // Ways younger than the touched one age by one; the touched way becomes MRU.
  always_comb begin
    lru_o = lru_i;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (lru_i[w] < lru_i[touch_way_i]) begin
        lru_o[w] = lru_i[w] + 2'd1;
      end
    end
    lru_o[touch_way_i] = '0;
  end

  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid_i[w]) begin
        victim_o = way_t'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (lru_i[w] == age_t'(NUM_WAYS - 1)) begin
          victim_o = way_t'(w);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller
// Description : 4-way set-associative data cache with 4-beat line refill.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_controller
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_cpu2cc,
  input  logic [ADR_WIDTH-1:0]  adr_cpu2cc,
  input  logic [DATA_WIDTH-1:0] dat_cpu2cc,
  input  logic                  rdwr_cpu2cc,
  input  logic                  lb_cpu2cc,
  input  logic                  lbu_cpu2cc,
  output logic                  ack_cc2cpu,
  output logic [DATA_WIDTH-1:0] dat_cc2cpu,
  output logic                  req_cc2mem,
  output logic [ADR_WIDTH-1:0]  adr_cc2mem,
  input  logic                  ack_mem2cc,
  input  logic [DATA_WIDTH-1:0] dat_mem2cc
);

  state_t state_q, state_d;

  logic [INDEX_WIDTH-1:0]   init_cnt_q;
  logic [TAG_WIDTH-1:0]     tag_q;
  logic [INDEX_WIDTH-1:0]   idx_q;
  logic [WORD_OFFSET-1:0]   word_q;
  logic [BYTE_OFFSET-1:0]   byte_q;
  logic [DATA_WIDTH-1:0]    wdat_q;
  logic                     rdwr_q, lb_q, lbu_q;
  way_t                     way_q;
  logic [1:0]               beat_q;
  logic [DATAMEM_WIDTH-DATA_WIDTH-1:0] line_q;
  logic                     req_mem_q;
  logic [ADR_WIDTH-1:0]     adr_mem_q;
  logic                     ack_q;
  logic [DATA_WIDTH-1:0]    dat_q;

  logic [NUM_WAYS-1:0]      valid_q [NUM_SETS];
  logic [TAG_WIDTH-1:0]     tags_q  [NUM_SETS][NUM_WAYS];
  logic [DATAMEM_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
  lru_t                     lru_q   [NUM_SETS];

  logic [NUM_WAYS-1:0]      hit_vec;
  way_t                     hit_way;
  way_t                     victim_way;
  lru_t                     lru_next;
  logic                     beat_ok;
  logic                     last_beat;
  logic [DATA_WIDTH-1:0]    cur_word;
  logic [DATA_WIDTH-1:0]    resp_data;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_hit
    assign hit_vec[w] = valid_q[idx_q][w] && (tags_q[idx_q][w] == tag_q);
  end

  always_comb begin
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = way_t'(w);
    end
  end

  cache_lru u_lru (
    .lru_i       (lru_q[idx_q]),
    .valid_i     (valid_q[idx_q]),
    .touch_way_i (way_q),
    .lru_o       (lru_next),
    .victim_o    (victim_way)
  );

  // A beat only counts once the request is actually visible to memory.
  assign beat_ok   = (state_q == ST_REFILL) && req_mem_q && ack_mem2cc;
  assign last_beat = beat_ok && (beat_q == 2'd3);

  assign cur_word = data_q[idx_q][way_q][word_q*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    resp_data = cur_word;
    if (lb_q) begin
      resp_data = load_byte(cur_word, byte_q, 1'b1);
    end else if (lbu_q) begin
      resp_data = load_byte(cur_word, byte_q, 1'b0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (&init_cnt_q) state_d = ST_IDLE;
      ST_IDLE:   if (req_cpu2cc) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = (|hit_vec) ? ST_RESP : ST_REFILL;
      ST_REFILL: if (last_beat) state_d = ST_RESP;
      ST_RESP:   state_d = ST_DONE;
      ST_DONE:   if (!req_cpu2cc) state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      init_cnt_q <= '0;
      tag_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      byte_q     <= '0;
      wdat_q     <= '0;
      rdwr_q     <= 1'b0;
      lb_q       <= 1'b0;
      lbu_q      <= 1'b0;
      way_q      <= '0;
      beat_q     <= '0;
      line_q     <= '0;
      req_mem_q  <= 1'b0;
      adr_mem_q  <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      ack_q <= 1'b0;
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;
      if (state_q == ST_IDLE && req_cpu2cc) begin
        {tag_q, idx_q, word_q, byte_q} <= adr_cpu2cc;
        wdat_q <= dat_cpu2cc;
        rdwr_q <= rdwr_cpu2cc;
        lb_q   <= lb_cpu2cc;
        lbu_q  <= lbu_cpu2cc;
      end
      if (state_q == ST_LOOKUP) begin
        way_q  <= (|hit_vec) ? hit_way : victim_way;
        beat_q <= '0;
      end
      if (state_q == ST_REFILL) begin
        req_mem_q <= !last_beat;
        adr_mem_q <= {tag_q, idx_q, {(WORD_OFFSET+BYTE_OFFSET){1'b0}}};
        if (beat_ok) beat_q <= beat_q + 2'd1;
        if (beat_ok && !last_beat) line_q[beat_q*DATA_WIDTH +: DATA_WIDTH] <= dat_mem2cc;
      end
      if (state_q == ST_RESP) begin
        ack_q <= 1'b1;
        if (!rdwr_q) dat_q <= resp_data;
      end
    end
  end

  // Arrays: valid/LRU are scrubbed by INIT; tag and valid land only with the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == ST_INIT) begin
        valid_q[init_cnt_q] <= '0;
        lru_q[init_cnt_q]   <= LRU_RESET;
      end
      if (last_beat) begin
        tags_q[idx_q][way_q]  <= tag_q;
        valid_q[idx_q][way_q] <= 1'b1;
        data_q[idx_q][way_q]  <= {dat_mem2cc, line_q};
      end
      if (state_q == ST_RESP) begin
        lru_q[idx_q] <= lru_next;
        if (rdwr_q) data_q[idx_q][way_q][word_q*DATA_WIDTH +: DATA_WIDTH] <= wdat_q;
      end
    end
  end

  assign ack_cc2cpu = ack_q;
  assign dat_cc2cpu = dat_q;
  assign req_cc2mem = req_mem_q;
  assign adr_cc2mem = adr_mem_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_controller
// Description : Directed self-checking bench for cache_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_cpu2cc = 1'b0;
  logic [31:0] adr_cpu2cc = '0;
  logic [31:0] dat_cpu2cc = '0;
  logic        rdwr_cpu2cc = 1'b0;
  logic        lb_cpu2cc = 1'b0;
  logic        lbu_cpu2cc = 1'b0;
  logic        ack_cc2cpu;
  logic [31:0] dat_cc2cpu;
  logic        req_cc2mem;
  logic [31:0] adr_cc2mem;
  logic        ack_mem2cc = 1'b0;
  logic [31:0] dat_mem2cc = '0;

  cache_controller dut (
    .clk         (clk),
    .rst         (rst),
    .req_cpu2cc  (req_cpu2cc),
    .adr_cpu2cc  (adr_cpu2cc),
    .dat_cpu2cc  (dat_cpu2cc),
    .rdwr_cpu2cc (rdwr_cpu2cc),
    .lb_cpu2cc   (lb_cpu2cc),
    .lbu_cpu2cc  (lbu_cpu2cc),
    .ack_cc2cpu  (ack_cc2cpu),
    .dat_cc2cpu  (dat_cc2cpu),
    .req_cc2mem  (req_cc2mem),
    .adr_cc2mem  (adr_cc2mem),
    .ack_mem2cc  (ack_mem2cc),
    .dat_mem2cc  (dat_mem2cc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] line_words [4];
  int          cfg_stall = 0;
  int          cfg_hold  = 0;
  int          cfg_abort = -1;

  logic        r_got_ack;
  logic [31:0] r_rdat;
  int          r_ack_cyc;
  logic        r_saw_req;
  logic [31:0] r_req_adr;
  int          r_req_cyc;
  int          r_extra;
  int          r_last_beat_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_line(input logic [31:0] w0, w1, w2, w3);
    line_words[0] = w0; line_words[1] = w1; line_words[2] = w2; line_words[3] = w3;
  endtask

  task automatic next_stall(output int s);
    s = (cfg_stall > 0) ? int'($urandom_range(1, cfg_stall)) : 0;
  endtask

  // Drives one CPU access and acts as the refill memory at the same time.
  task automatic cpu_access(input logic [31:0] adr, input logic wr, input logic [31:0] wdat,
                            input logic lb, input logic lbu);
    int cyc, beat, stall;
    logic aborted;
    @(negedge clk);
    req_cpu2cc = 1'b1; adr_cpu2cc = adr; rdwr_cpu2cc = wr; dat_cpu2cc = wdat;
    lb_cpu2cc = lb; lbu_cpu2cc = lbu;
    r_got_ack = 1'b0; r_saw_req = 1'b0; r_extra = 0; r_ack_cyc = -1; r_req_cyc = -1;
    r_req_adr = '0; r_rdat = '0; r_last_beat_cyc = -1;
    cyc = 0; beat = 0; aborted = 1'b0;
    next_stall(stall);
    while (!r_got_ack && !aborted && cyc < 200) begin
      @(negedge clk);
      cyc++;
      ack_mem2cc = 1'b0;
      if (ack_cc2cpu) begin
        r_got_ack = 1'b1; r_rdat = dat_cc2cpu; r_ack_cyc = cyc;
      end else if (req_cc2mem && beat < 4) begin
        if (!r_saw_req) begin
          r_saw_req = 1'b1; r_req_adr = adr_cc2mem; r_req_cyc = cyc;
        end
        if (stall > 0) begin
          stall--;
        end else begin
          if (beat == cfg_abort) begin
            rst = 1'b0; aborted = 1'b1;
          end
          ack_mem2cc = 1'b1; dat_mem2cc = line_words[beat];
          r_last_beat_cyc = cyc;
          beat++;
          next_stall(stall);
        end
      end
    end
    if (aborted) begin
      @(negedge clk);
      ack_mem2cc = 1'b0; req_cpu2cc = 1'b0;
    end else begin
      for (int h = 0; h <= cfg_hold; h++) begin
        @(negedge clk);
        if (ack_cc2cpu) r_extra++;
      end
      req_cpu2cc = 1'b0; lb_cpu2cc = 1'b0; lbu_cpu2cc = 1'b0; rdwr_cpu2cc = 1'b0;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] adr, input logic wr,
                     input logic [31:0] wdat, input logic lb, input logic lbu,
                     input logic exp_miss, input logic chk_dat, input logic [31:0] exp_dat);
    cpu_access(adr, wr, wdat, lb, lbu);
    check({tag, "_ack"}, {31'b0, r_got_ack}, 32'd1);
    check({tag, "_miss"}, {31'b0, r_saw_req}, {31'b0, exp_miss});
    check({tag, "_pulse"}, r_extra, 0);
    if (chk_dat) check({tag, "_dat"}, r_rdat, exp_dat);
  endtask

  initial begin
    int ign;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'b0, ack_cc2cpu}, 0);
    check("rst_dat", dat_cc2cpu, 0);
    check("rst_req", {31'b0, req_cc2mem}, 0);
    check("rst_adr", adr_cc2mem, 0);
    rst = 1'b1;

    // Requests during INIT are ignored
    repeat (10) @(negedge clk);
    req_cpu2cc = 1'b1; adr_cpu2cc = 32'hFF07BD08;
    ign = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_cc2cpu || req_cc2mem) ign++;
    end
    req_cpu2cc = 1'b0;
    check("init_ignore", ign, 0);
    repeat (300) @(negedge clk);

    // First miss: latency and refill address
    set_line(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run("miss0", 32'hFF07BD08, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
    check("miss0_adr", r_req_adr, 32'hFF07BD00);
    check("miss0_reqcyc", r_req_cyc, 3);
    check("miss0_ackcyc", r_ack_cyc, r_last_beat_cyc + 2);

    // Fill the remaining ways of set 0xD0
    set_line(32'h11110000, 32'h11110001, 32'h11110002, 32'h11110003);
    run("fill1", 32'hA5552D00, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11110000);
    set_line(32'h22220000, 32'h22220001, 32'h22220002, 32'h22220003);
    run("fill2", 32'hD500AD04, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22220001);
    set_line(32'h33330000, 32'h33330001, 32'h33330002, 32'h33330003);
    run("fill3", 32'hFFFFFD0C, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33330003);
    run("hit0", 32'hFF07BD00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    check("hit0_ackcyc", r_ack_cyc, 3);

    // Write hit, LRU eviction of D500A, hits on surviving ways
    run("wr0", 32'hA5552D08, 1'b1, 32'hAA8AAAA4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    set_line(32'h44440000, 32'h44440001, 32'h44440002, 32'h44440003);
    run("evict", 32'hAFD52D08, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44440002);
    run("rd_wr0", 32'hA5552D08, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAA8AAAA4);
    run("rd_ff07b", 32'hFF07BD04, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    set_line(32'h22220000, 32'h22220001, 32'h22220002, 32'h22220003);
    run("d500a_gone", 32'hD500AD00, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22220000);

    // Byte loads, big-endian lanes
    run("wr1", 32'hA5552D0C, 1'b1, 32'hAAEBAAB4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("lbu0", 32'hA5552D0C, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h000000AA);
    run("lb0",  32'hA5552D0C, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFAA);
    run("lbu1", 32'hA5552D0D, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h000000EB);
    run("lb1",  32'hA5552D0D, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFEB);
    run("lb3",  32'hA5552D0F, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFB4);

    // Stalled refill: words must land in beat order
    cfg_stall = 10;
    set_line(32'h0BADF00D, 32'hCAFEBABE, 32'hDEADBEEF, 32'h8BADF00D);
    run("stall", 32'h12345670, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0BADF00D);
    check("stall_adr", r_req_adr, 32'h12345670);
    cfg_stall = 0;
    run("stall_w1", 32'h12345674, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEBABE);
    run("stall_w3", 32'h1234567C, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8BADF00D);

    // Held request is served once
    cfg_hold = 3;
    run("hold", 32'h12345678, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    cfg_hold = 0;
    run("rearm", 32'h12345674, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEBABE);

    // Reset during beat 2 aborts the refill
    cfg_abort = 2;
    set_line(32'h5A5A0000, 32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003);
    cpu_access(32'h55555500, 1'b0, 0, 1'b0, 1'b0);
    cfg_abort = -1;
    check("abort_noack", {31'b0, r_got_ack}, 0);
    repeat (2) @(negedge clk);
    check("abort_req", {31'b0, req_cc2mem}, 0);
    rst = 1'b1;
    repeat (260) @(negedge clk);
    set_line(32'h6B6B0000, 32'h6B6B0001, 32'h6B6B0002, 32'h6B6B0003);
    run("after_abort", 32'h55555500, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h6B6B0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
